// File: rtl/traffic_pkg.sv
// Shared definitions for the traffic-light controllers: phase encodings and lamp codes.
package traffic_pkg;

  typedef enum logic [1:0] {
    PH_GREEN  = 2'b00,
    PH_YELLOW = 2'b01,
    PH_ALLRED = 2'b10
  } phase_e;

  localparam logic [2:0] LAMP_RED = 3'b100;
  localparam logic [2:0] LAMP_YEL = 3'b010;
  localparam logic [2:0] LAMP_GRN = 3'b001;

endpackage

// File: rtl/traffic_ctrl_nway_if.sv
// Sensor/lamp bundle of the N-approach controller; the sensor side is the master.
interface traffic_ctrl_nway_if #(
  parameter int NUM_DIR = 4
);
  localparam int DW = $clog2(NUM_DIR);

  logic [NUM_DIR-1:0]   car;
  logic [3*NUM_DIR-1:0] light;
  logic [DW-1:0]        active_dir;
  logic [1:0]           phase;

  modport master (output car, input light, input active_dir, input phase);
  modport slave  (input car, output light, output active_dir, output phase);

endinterface

// File: rtl/traffic_ctrl_nway_rr_next_sel.sv
// Round-robin search: nearest approach after active_dir (with wrap-around) that has a car.
module rr_next_sel #(
  parameter int NUM_DIR = 4,
  parameter int DW      = $clog2(NUM_DIR)
) (
  input  logic [NUM_DIR-1:0] car,
  input  logic [DW-1:0]      active_dir,
  output logic [DW-1:0]      next_dir,
  output logic               found
);

  function automatic logic [DW-1:0] wrap_add(input logic [DW-1:0] base, input int unsigned ofs);
    int unsigned sum_s;
    sum_s = 32'(base) + ofs;
    if (sum_s >= 32'(NUM_DIR)) begin
      sum_s = sum_s - 32'(NUM_DIR);
    end else begin
      sum_s = sum_s;
    end
    return DW'(sum_s);
  endfunction

  // Scan farthest-to-nearest so the nearest requester overrides; active_dir itself is never a candidate.
  always_comb begin
    next_dir = active_dir;
    found    = 1'b0;
    for (int k = NUM_DIR - 1; k >= 1; k--) begin
      if (car[wrap_add(active_dir, 32'(k))]) begin
        next_dir = wrap_add(active_dir, 32'(k));
        found    = 1'b1;
      end else begin
        next_dir = next_dir;
        found    = found;
      end
    end
  end

endmodule

// File: rtl/traffic_ctrl_nway.sv
// N-approach traffic-light controller: round-robin green grant with min/max green,
// yellow and all-red clearance. Lamps are decoded from registered phase and active_dir only.
module traffic_ctrl_nway
  import traffic_pkg::*;
#(
  parameter int NUM_DIR    = 4,
  parameter int MIN_GREEN  = 3,
  parameter int MAX_GREEN  = 8,
  parameter int YELLOW_CYC = 2,
  parameter int ALLRED_CYC = 1
) (
  input  logic               clk,
  input  logic               rst,
  traffic_ctrl_nway_if.slave bus
);

  localparam int DW       = $clog2(NUM_DIR);
  localparam int SAT_A    = (MAX_GREEN > YELLOW_CYC) ? MAX_GREEN : YELLOW_CYC;
  localparam int TMR_SAT  = (SAT_A > ALLRED_CYC) ? SAT_A : ALLRED_CYC;
  localparam int TW       = $clog2(TMR_SAT + 1);

  phase_e               phase_r;
  logic [DW-1:0]        active_dir_r;
  logic [DW-1:0]        next_dir_r;
  logic [TW-1:0]        tmr_r;
  logic [TW-1:0]        tmr_inc_s;
  logic [DW-1:0]        sel_dir_s;
  logic                 sel_found_s;
  logic                 other_req_s;
  logic                 handover_s;
  logic [3*NUM_DIR-1:0] light_s;

  rr_next_sel #(
    .NUM_DIR (NUM_DIR),
    .DW      (DW)
  ) u_rr (
    .car        (bus.car),
    .active_dir (active_dir_r),
    .next_dir   (sel_dir_s),
    .found      (sel_found_s)
  );

  // The search reports a hit exactly when some approach other than the holder has a car.
  assign other_req_s = sel_found_s;
  assign tmr_inc_s   = (tmr_r >= TW'(TMR_SAT)) ? tmr_r : tmr_r + TW'(1);
  assign handover_s  = other_req_s && (tmr_r >= TW'(MIN_GREEN - 1)) &&
                       (!bus.car[active_dir_r] || (tmr_r >= TW'(MAX_GREEN - 1)));

  // Phase FSM with timer and committed next_dir; illegal phase falls back to the reset state.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      phase_r      <= PH_GREEN;
      active_dir_r <= {DW{1'b0}};
      next_dir_r   <= {DW{1'b0}};
      tmr_r        <= {TW{1'b0}};
    end else begin
      case (phase_r)
        PH_GREEN: begin
          if (handover_s) begin
            phase_r    <= PH_YELLOW;
            next_dir_r <= sel_dir_s;
            tmr_r      <= {TW{1'b0}};
          end else begin
            tmr_r <= tmr_inc_s;
          end
        end
        PH_YELLOW: begin
          if (tmr_r >= TW'(YELLOW_CYC - 1)) begin
            tmr_r <= {TW{1'b0}};
            if (ALLRED_CYC == 0) begin
              phase_r      <= PH_GREEN;
              active_dir_r <= next_dir_r;
            end else begin
              phase_r <= PH_ALLRED;
            end
          end else begin
            tmr_r <= tmr_inc_s;
          end
        end
        PH_ALLRED: begin
          if (tmr_r >= TW'(ALLRED_CYC - 1)) begin
            phase_r      <= PH_GREEN;
            active_dir_r <= next_dir_r;
            tmr_r        <= {TW{1'b0}};
          end else begin
            tmr_r <= tmr_inc_s;
          end
        end
        default: begin
          phase_r      <= PH_GREEN;
          active_dir_r <= {DW{1'b0}};
          next_dir_r   <= {DW{1'b0}};
          tmr_r        <= {TW{1'b0}};
        end
      endcase
    end
  end

  for (genvar i = 0; i < NUM_DIR; i++) begin : g_lamp
    assign light_s[3*i +: 3] =
      ((phase_r == PH_GREEN)  && (active_dir_r == DW'(i))) ? LAMP_GRN :
      ((phase_r == PH_YELLOW) && (active_dir_r == DW'(i))) ? LAMP_YEL : LAMP_RED;
  end

  assign bus.light      = light_s;
  assign bus.active_dir = active_dir_r;
  assign bus.phase      = phase_r;

endmodule

// File: tb/tb_traffic_ctrl_nway.sv
// Directed bench for traffic_ctrl_nway: one default build and one build without all-red.
module tb_traffic_ctrl_nway;
  import traffic_pkg::*;

  localparam logic [11:0] L_RESET = 12'b100_100_100_001;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;

  traffic_ctrl_nway_if #(.NUM_DIR(4)) bus_a ();
  traffic_ctrl_nway_if #(.NUM_DIR(4)) bus_b ();

  traffic_ctrl_nway #(.NUM_DIR(4), .MIN_GREEN(3), .MAX_GREEN(8), .YELLOW_CYC(2), .ALLRED_CYC(1))
    dut_a (.clk(clk), .rst(rst), .bus(bus_a));
  traffic_ctrl_nway #(.NUM_DIR(4), .MIN_GREEN(3), .MAX_GREEN(8), .YELLOW_CYC(2), .ALLRED_CYC(0))
    dut_b (.clk(clk), .rst(rst), .bus(bus_b));

  always #5 clk = ~clk;

  logic [11:0] mon_light [2];
  logic [1:0]  mon_phase [2];
  logic [2:0]  mon_lamp;
  logic        mon_bad;
  int          mon_lit;
  int          mon_exp;

  // Every cycle out of reset: lamp codes legal, one lit approach in GREEN/YELLOW, none in ALLRED.
  always @(negedge clk) begin
    if (rst === 1'b0) begin
      mon_light[0] = bus_a.light;
      mon_phase[0] = bus_a.phase;
      mon_light[1] = bus_b.light;
      mon_phase[1] = bus_b.phase;
      for (int u = 0; u < 2; u++) begin
        mon_bad = (mon_phase[u] == 2'b11);
        mon_lit = 0;
        for (int i = 0; i < 4; i++) begin
          mon_lamp = mon_light[u][3*i +: 3];
          if (mon_lamp != LAMP_RED && mon_lamp != LAMP_YEL && mon_lamp != LAMP_GRN) mon_bad = 1'b1;
          if (mon_lamp != LAMP_RED) mon_lit++;
        end
        mon_exp = (mon_phase[u] == 2'b10) ? 0 : 1;
        checks++;
        if (mon_bad || mon_lit != mon_exp) begin
          errors++;
          $display("FAIL lamp_legal dut%0d cyc=%0d: light=%b phase=%b lit=%0d, required lit=%0d legal codes",
                   u, cyc, mon_light[u], mon_phase[u], mon_lit, mon_exp);
        end
      end
    end
  end

  task automatic do_reset(input logic [3:0] car_a, input logic [3:0] car_b);
    rst = 1'b1;
    bus_a.car = car_a;
    bus_b.car = car_b;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    cyc = 0;
  endtask

  task automatic step();
    @(negedge clk);
    cyc++;
  endtask

  task automatic test_reset();
    do_reset(4'b0000, 4'b0000);
    for (int n = 0; n < 50; n++) begin
      checks++;
      if (bus_a.light !== L_RESET || bus_a.phase !== 2'b00 || bus_a.active_dir !== 2'd0) begin
        errors++;
        $display("FAIL reset_idle cyc=%0d: light=%b phase=%b dir=%0d, required %b 00 0",
                 cyc, bus_a.light, bus_a.phase, bus_a.active_dir, L_RESET);
      end
      step();
    end
  endtask

  task automatic test_single_request();
    logic [1:0]  exp_ph [0:6];
    logic [1:0]  exp_dir [0:6];
    logic [11:0] exp_l [0:6];
    exp_ph  = '{2'b00, 2'b00, 2'b00, 2'b01, 2'b01, 2'b10, 2'b00};
    exp_dir = '{2'd0, 2'd0, 2'd0, 2'd0, 2'd0, 2'd0, 2'd2};
    exp_l   = '{L_RESET, L_RESET, L_RESET, 12'b100_100_100_010, 12'b100_100_100_010,
                12'b100_100_100_100, 12'b100_001_100_100};
    do_reset(4'b0100, 4'b0000);
    for (int c = 0; c <= 6; c++) begin
      checks++;
      if (bus_a.phase !== exp_ph[c] || bus_a.active_dir !== exp_dir[c] || bus_a.light !== exp_l[c]) begin
        errors++;
        $display("FAIL single_req cyc=%0d: phase=%b dir=%0d light=%b, required %b %0d %b",
                 cyc, bus_a.phase, bus_a.active_dir, bus_a.light, exp_ph[c], exp_dir[c], exp_l[c]);
      end
      step();
    end
  endtask

  task automatic test_round_robin();
    logic [11:0] exp_l;
    int          d;
    do_reset(4'b1111, 4'b0000);
    while (cyc <= 44) begin
      d = (cyc / 11) % 4;
      exp_l = {4{3'b100}};
      exp_l[3*d +: 3] = 3'b001;
      if (cyc % 11 == 0 || cyc % 11 == 7) begin
        checks++;
        if (bus_a.phase !== 2'b00 || bus_a.active_dir !== 2'(d) || bus_a.light !== exp_l) begin
          errors++;
          $display("FAIL rr_green cyc=%0d: phase=%b dir=%0d light=%b, required 00 %0d %b",
                   cyc, bus_a.phase, bus_a.active_dir, bus_a.light, d, exp_l);
        end
      end
      if (cyc % 11 == 8 && cyc < 44) begin
        checks++;
        if (bus_a.phase !== 2'b01 || bus_a.active_dir !== 2'(d)) begin
          errors++;
          $display("FAIL rr_yellow cyc=%0d: phase=%b dir=%0d, required 01 %0d",
                   cyc, bus_a.phase, bus_a.active_dir, d);
        end
      end
      if (cyc % 11 == 10 && cyc < 44) begin
        checks++;
        if (bus_a.phase !== 2'b10 || bus_a.light !== 12'b100_100_100_100) begin
          errors++;
          $display("FAIL rr_allred cyc=%0d: phase=%b light=%b, required 10 all red",
                   cyc, bus_a.phase, bus_a.light);
        end
      end
      step();
    end
  endtask

  task automatic test_wraparound();
    do_reset(4'b0010, 4'b0000);
    while (cyc < 11) step();
    bus_a.car = 4'b0011;
    while (cyc <= 17) begin
      if (cyc >= 11 && cyc <= 13) begin
        checks++;
        if (bus_a.phase !== 2'b00 || bus_a.active_dir !== 2'd1) begin
          errors++;
          $display("FAIL wrap_hold cyc=%0d: phase=%b dir=%0d, required 00 1",
                   cyc, bus_a.phase, bus_a.active_dir);
        end
      end
      if (cyc == 14) begin
        checks++;
        if (bus_a.phase !== 2'b01 || bus_a.light !== 12'b100_100_010_100) begin
          errors++;
          $display("FAIL wrap_yellow cyc=%0d: phase=%b light=%b, required 01 100100010100",
                   cyc, bus_a.phase, bus_a.light);
        end
      end
      if (cyc == 17) begin
        checks++;
        if (bus_a.phase !== 2'b00 || bus_a.active_dir !== 2'd0 || bus_a.light !== L_RESET) begin
          errors++;
          $display("FAIL wrap_grant cyc=%0d: phase=%b dir=%0d light=%b, required 00 0 %b",
                   cyc, bus_a.phase, bus_a.active_dir, bus_a.light, L_RESET);
        end
      end
      step();
    end
  endtask

  task automatic test_commit_next_dir();
    do_reset(4'b0100, 4'b0000);
    while (cyc < 3) step();
    bus_a.car = 4'b0010;
    while (cyc <= 12) begin
      if (cyc == 6 || cyc == 8) begin
        checks++;
        if (bus_a.phase !== 2'b00 || bus_a.active_dir !== 2'd2) begin
          errors++;
          $display("FAIL commit_grant cyc=%0d: phase=%b dir=%0d, required 00 2",
                   cyc, bus_a.phase, bus_a.active_dir);
        end
      end
      if (cyc == 9) begin
        checks++;
        if (bus_a.phase !== 2'b01 || bus_a.active_dir !== 2'd2) begin
          errors++;
          $display("FAIL commit_min_green cyc=%0d: phase=%b dir=%0d, required 01 2",
                   cyc, bus_a.phase, bus_a.active_dir);
        end
      end
      if (cyc == 12) begin
        checks++;
        if (bus_a.phase !== 2'b00 || bus_a.active_dir !== 2'd1) begin
          errors++;
          $display("FAIL commit_next cyc=%0d: phase=%b dir=%0d, required 00 1",
                   cyc, bus_a.phase, bus_a.active_dir);
        end
      end
      step();
    end
  endtask

  task automatic test_async_reset();
    do_reset(4'b1000, 4'b0000);
    while (cyc < 6) step();
    bus_a.car = 4'b0001;
    while (cyc < 9) step();
    checks++;
    if (bus_a.phase !== 2'b01 || bus_a.active_dir !== 2'd3 || bus_a.light !== 12'b010_100_100_100) begin
      errors++;
      $display("FAIL areset_pre cyc=%0d: phase=%b dir=%0d light=%b, required 01 3 010100100100",
               cyc, bus_a.phase, bus_a.active_dir, bus_a.light);
    end
    #2;
    rst = 1'b1;
    #1;
    checks++;
    if (bus_a.light !== L_RESET || bus_a.phase !== 2'b00 || bus_a.active_dir !== 2'd0) begin
      errors++;
      $display("FAIL areset_now: light=%b phase=%b dir=%0d, required %b 00 0",
               bus_a.light, bus_a.phase, bus_a.active_dir, L_RESET);
    end
    @(negedge clk);
    rst = 1'b0;
    cyc = 0;
    for (int n = 0; n < 5; n++) begin
      checks++;
      if (bus_a.phase !== 2'b00 || bus_a.active_dir !== 2'd0) begin
        errors++;
        $display("FAIL areset_resume cyc=%0d: phase=%b dir=%0d, required 00 0",
                 cyc, bus_a.phase, bus_a.active_dir);
      end
      step();
    end
  endtask

  task automatic test_no_allred();
    logic [1:0] exp_ph;
    logic [1:0] exp_dir;
    do_reset(4'b0000, 4'b0010);
    while (cyc <= 8) begin
      exp_ph  = (cyc == 3 || cyc == 4) ? 2'b01 : 2'b00;
      exp_dir = (cyc >= 5) ? 2'd1 : 2'd0;
      checks++;
      if (bus_b.phase !== exp_ph || bus_b.active_dir !== exp_dir) begin
        errors++;
        $display("FAIL no_allred cyc=%0d: phase=%b dir=%0d, required %b %0d",
                 cyc, bus_b.phase, bus_b.active_dir, exp_ph, exp_dir);
      end
      if (cyc == 5) begin
        checks++;
        if (bus_b.light !== 12'b100_100_001_100) begin
          errors++;
          $display("FAIL no_allred_light cyc=%0d: light=%b, required 100100001100", cyc, bus_b.light);
        end
      end
      step();
    end
  endtask

  initial begin
    bus_a.car = 4'b0000;
    bus_b.car = 4'b0000;
    test_reset();
    test_single_request();
    test_round_robin();
    test_wraparound();
    test_commit_next_dir();
    test_async_reset();
    test_no_allred();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
